div_by_five_serial_tx: RTL and testbench

//  Transmit end of the divide-by-five serial link: accepts a parallel word over a

---
 rtl/div_by_five_pkg.sv | 13 +
 rtl/div_by_five_mod_step.sv | 32 +++
 rtl/div_by_five_serial_tx.sv | 120 ++++++++++++
 tb/tb_div_by_five_serial_tx.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/div_by_five_pkg.sv
// rtl/div_by_five_pkg.sv - shared types and defaults for the divide-by-five serial link
package div_by_five_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int DEFAULT_WIDTH   = 8;
  localparam int DEFAULT_DIVISOR = 5;

endpackage

// File: rtl/div_by_five_mod_step.sv
// rtl/div_by_five_mod_step.sv - one MSB-first step of a running remainder mod DIVISOR
// Ports:
//   rem_in  [RW-1:0]  remainder of the bits seen so far
//   bit_in            next bit (appended as new LSB)
//   rem_out [RW-1:0]  (2*rem_in + bit_in) mod DIVISOR
module div_by_five_mod_step
  import div_by_five_pkg::*;
#(
  parameter  int DIVISOR = DEFAULT_DIVISOR,
  localparam int RW      = $clog2(DIVISOR)
) (
  input  logic [RW-1:0] rem_in,
  input  logic          bit_in,
  output logic [RW-1:0] rem_out
);

  localparam logic [RW:0] DIV_W = (RW+1)'(DIVISOR);

  logic [RW:0] sum;

  // rem_in < DIVISOR, so sum < 2*DIVISOR: a single conditional subtract
  // brings it back into range.
  always_comb begin
    sum = {rem_in, bit_in};
    if (sum >= DIV_W) begin
      rem_out = RW'(sum - DIV_W);
    end else begin
      rem_out = sum[RW-1:0];
    end
  end

endmodule

// File: rtl/div_by_five_serial_tx.sv
// rtl/div_by_five_serial_tx.sv - parallel-in, MSB-first serial transmitter with running remainder
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   in_val/in_rdy       parallel word handshake (in_rdy high only in IDLE)
//   in_data [WIDTH-1:0] word to serialise
//   ser_val/ser_rdy     serial beat handshake
//   ser_bit, ser_last   current bit (MSB first) and last-bit marker
//   stat_val            one-cycle frame-complete pulse
//   stat_rem [RW-1:0]   word mod DIVISOR; stat_div = (stat_rem == 0)
module div_by_five_serial_tx
  import div_by_five_pkg::*;
#(
  parameter  int WIDTH   = DEFAULT_WIDTH,
  parameter  int DIVISOR = DEFAULT_DIVISOR,
  localparam int RW      = $clog2(DIVISOR)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_val,
  output logic             in_rdy,
  input  logic [WIDTH-1:0] in_data,
  output logic             ser_val,
  input  logic             ser_rdy,
  output logic             ser_bit,
  output logic             ser_last,
  output logic             stat_val,
  output logic [RW-1:0]    stat_rem,
  output logic             stat_div
);

  // Counter stays at least one bit wide so WIDTH=1 still builds.
  localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [RW-1:0]    rem_q, rem_d;
  logic [RW-1:0]    stat_rem_q, stat_rem_d;
  logic             stat_div_q, stat_div_d;
  logic [RW-1:0]    rem_step;

  div_by_five_mod_step #(
    .DIVISOR (DIVISOR)
  ) u_mod_step (
    .rem_in  (rem_q),
    .bit_in  (shreg_q[WIDTH-1]),
    .rem_out (rem_step)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      cnt_q      <= '0;
      rem_q      <= '0;
      stat_rem_q <= '0;
      stat_div_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      stat_rem_q <= stat_rem_d;
      stat_div_q <= stat_div_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    stat_rem_d = stat_rem_q;
    stat_div_d = stat_div_q;
    in_rdy     = 1'b0;
    ser_val    = 1'b0;
    ser_bit    = 1'b0;
    ser_last   = 1'b0;
    stat_val   = 1'b0;

    case (state_q)
      IDLE: begin
        in_rdy = 1'b1;
        if (in_val) begin
          shreg_d = in_data;
          cnt_d   = CNT_LOAD;
          rem_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        ser_val  = 1'b1;
        ser_bit  = shreg_q[WIDTH-1];
        ser_last = (cnt_q == '0);
        // Without ser_rdy everything holds, so the bit is re-offered.
        if (ser_rdy) begin
          rem_d   = rem_step;
          shreg_d = shreg_q << 1;
          cnt_d   = cnt_q - CW'(1);
          if (ser_last) begin
            // Status is captured separately so it survives the next frame's rem clear.
            stat_rem_d = rem_step;
            stat_div_d = (rem_step == '0);
            state_d    = DONE;
          end
        end
      end
      DONE: begin
        stat_val = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign stat_rem = stat_rem_q;
  assign stat_div = stat_div_q;

endmodule

// File: tb/tb_div_by_five_serial_tx.sv
// tb/tb_div_by_five_serial_tx.sv - self-checking bench for div_by_five_serial_tx
module tb_div_by_five_serial_tx;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Instance A: WIDTH=8, DIVISOR=5
  logic       a_in_val, a_in_rdy, a_ser_val, a_ser_rdy, a_ser_bit, a_ser_last;
  logic       a_stat_val, a_stat_div;
  logic [7:0] a_in_data;
  logic [2:0] a_stat_rem;
  // Instance B: WIDTH=8, DIVISOR=3
  logic       b_in_val, b_in_rdy, b_ser_val, b_ser_rdy, b_ser_bit, b_ser_last;
  logic       b_stat_val, b_stat_div;
  logic [7:0] b_in_data;
  logic [1:0] b_stat_rem;
  // Instance C: WIDTH=1, DIVISOR=3
  logic       c_in_val, c_in_rdy, c_ser_val, c_ser_rdy, c_ser_bit, c_ser_last;
  logic       c_stat_val, c_stat_div;
  logic [0:0] c_in_data;
  logic [1:0] c_stat_rem;

  div_by_five_serial_tx #(.WIDTH(8), .DIVISOR(5)) dut_a (
    .clk(clk), .rst(rst), .in_val(a_in_val), .in_rdy(a_in_rdy), .in_data(a_in_data),
    .ser_val(a_ser_val), .ser_rdy(a_ser_rdy), .ser_bit(a_ser_bit), .ser_last(a_ser_last),
    .stat_val(a_stat_val), .stat_rem(a_stat_rem), .stat_div(a_stat_div)
  );
  div_by_five_serial_tx #(.WIDTH(8), .DIVISOR(3)) dut_b (
    .clk(clk), .rst(rst), .in_val(b_in_val), .in_rdy(b_in_rdy), .in_data(b_in_data),
    .ser_val(b_ser_val), .ser_rdy(b_ser_rdy), .ser_bit(b_ser_bit), .ser_last(b_ser_last),
    .stat_val(b_stat_val), .stat_rem(b_stat_rem), .stat_div(b_stat_div)
  );
  div_by_five_serial_tx #(.WIDTH(1), .DIVISOR(3)) dut_c (
    .clk(clk), .rst(rst), .in_val(c_in_val), .in_rdy(c_in_rdy), .in_data(c_in_data),
    .ser_val(c_ser_val), .ser_rdy(c_ser_rdy), .ser_bit(c_ser_bit), .ser_last(c_ser_last),
    .stat_val(c_stat_val), .stat_rem(c_stat_rem), .stat_div(c_stat_div)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // mode 0: ser_rdy=1; mode 1: 1,0,0,1 repeating; mode 2: random
  task automatic frame_a(input logic [7:0] word, input int mode, input bit keep_val,
                         output int acc);
    int t = 0;
    int k = 0;
    int beat = 0;
    bit r;
    a_in_data = word;
    a_in_val  = 1'b1;
    while (!a_in_rdy && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk("a_accept_timeout", 32'(t < 40), 1);
    acc = cyc;
    @(negedge clk);
    if (!keep_val) a_in_val = 1'b0;
    while (k < 8 && beat < 100) begin
      chk("a_ser_val", a_ser_val, 1);
      chk("a_ser_bit", a_ser_bit, word[7-k]);
      chk("a_ser_last", a_ser_last, 32'(k == 7));
      chk("a_stat_val_mid", a_stat_val, 0);
      case (mode)
        0:       r = 1'b1;
        1:       r = (beat % 4 == 0) || (beat % 4 == 3);
        default: r = 1'($urandom_range(0, 1));
      endcase
      a_ser_rdy = r;
      a_in_data = 8'($urandom);
      @(negedge clk);
      if (r) k++;
      beat++;
    end
    chk("a_stat_val", a_stat_val, 1);
    chk("a_stat_rem", a_stat_rem, 32'(word % 5));
    chk("a_stat_div", a_stat_div, 32'(word % 5 == 0));
    chk("a_ser_val_done", a_ser_val, 0);
    a_ser_rdy = 1'b1;
    @(negedge clk);
    chk("a_stat_val_pulse", a_stat_val, 0);
    chk("a_in_rdy_after", a_in_rdy, 1);
    chk("a_stat_rem_hold", a_stat_rem, 32'(word % 5));
  endtask

  task automatic frame_b(input logic [7:0] word);
    int t = 0;
    int k = 0;
    int beat = 0;
    bit r;
    b_in_data = word;
    b_in_val  = 1'b1;
    while (!b_in_rdy && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk("b_accept_timeout", 32'(t < 40), 1);
    @(negedge clk);
    b_in_val = 1'b0;
    while (k < 8 && beat < 100) begin
      chk("b_ser_bit", b_ser_bit, word[7-k]);
      chk("b_ser_last", b_ser_last, 32'(k == 7));
      r = 1'($urandom_range(0, 1));
      b_ser_rdy = r;
      @(negedge clk);
      if (r) k++;
      beat++;
    end
    chk("b_stat_val", b_stat_val, 1);
    chk("b_stat_rem", b_stat_rem, 32'(word % 3));
    chk("b_stat_div", b_stat_div, 32'(word % 3 == 0));
    b_ser_rdy = 1'b1;
    @(negedge clk);
  endtask

  task automatic frame_c(input logic [0:0] word);
    int t = 0;
    int beat = 0;
    c_in_data = word;
    c_in_val  = 1'b1;
    while (!c_in_rdy && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk("c_accept_timeout", 32'(t < 40), 1);
    @(negedge clk);
    c_in_val  = 1'b0;
    c_ser_rdy = 1'b0;
    // Hold off for a random number of cycles; the single bit must stay put.
    repeat ($urandom_range(0, 2)) begin
      chk("c_ser_val_hold", c_ser_val, 1);
      chk("c_ser_bit_hold", c_ser_bit, word);
      @(negedge clk);
      beat++;
    end
    chk("c_ser_val", c_ser_val, 1);
    chk("c_ser_bit", c_ser_bit, word);
    chk("c_ser_last", c_ser_last, 1);
    c_ser_rdy = 1'b1;
    @(negedge clk);
    chk("c_stat_val", c_stat_val, 1);
    chk("c_stat_rem", c_stat_rem, 32'(word % 3));
    chk("c_stat_div", c_stat_div, 32'(word == 0));
    @(negedge clk);
    chk("c_in_rdy_after", c_in_rdy, 1);
  endtask

  initial begin
    int acc1;
    int acc2;
    rst = 1'b1;
    a_in_val = 0; a_in_data = 0; a_ser_rdy = 1;
    b_in_val = 0; b_in_data = 0; b_ser_rdy = 1;
    c_in_val = 0; c_in_data = 0; c_ser_rdy = 1;
    repeat (2) @(negedge clk);
    chk("rst_in_rdy", a_in_rdy, 1);
    chk("rst_ser_val", a_ser_val, 0);
    chk("rst_ser_bit", a_ser_bit, 0);
    chk("rst_ser_last", a_ser_last, 0);
    chk("rst_stat_val", a_stat_val, 0);
    chk("rst_stat_rem", a_stat_rem, 0);
    chk("rst_stat_div", a_stat_div, 0);
    rst = 1'b0;
    @(negedge clk);

    // Directed words with ser_rdy held high
    frame_a(8'd25, 0, 0, acc1);
    frame_a(8'd27, 0, 0, acc1);
    frame_a(8'hFF, 0, 0, acc1);
    frame_a(8'h00, 0, 0, acc1);

    // Backpressure 1,0,0,1,...
    frame_a(8'd27, 1, 0, acc1);

    // in_val held high: back-to-back frames, in_data scrambled during SHIFT
    frame_a(8'h5A, 0, 1, acc1);
    frame_a(8'hC3, 0, 0, acc2);
    chk("a_throughput", 32'(acc2 - acc1), 10);

    // Reset after three accepted bits
    a_in_data = 8'd200;
    a_in_val  = 1'b1;
    @(negedge clk);
    a_in_val  = 1'b0;
    a_ser_rdy = 1'b1;
    repeat (3) @(negedge clk);
    chk("a_pre_abort_ser_val", a_ser_val, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("a_abort_ser_val", a_ser_val, 0);
    chk("a_abort_stat_val", a_stat_val, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("a_abort_in_rdy", a_in_rdy, 1);
    chk("a_abort_no_stat", a_stat_val, 0);
    frame_a(8'd10, 0, 0, acc1);

    // Reset and in_val together: the word must not be taken
    a_in_data = 8'd77;
    a_in_val  = 1'b1;
    rst       = 1'b1;
    @(negedge clk);
    rst      = 1'b0;
    a_in_val = 1'b0;
    chk("a_rst_wins_ser_val", a_ser_val, 0);
    @(negedge clk);
    chk("a_rst_wins_idle", a_ser_val, 0);
    chk("a_rst_wins_no_stat", a_stat_val, 0);

    // Random words against word % DIVISOR
    repeat (20) frame_a(8'($urandom), 2, 0, acc1);
    repeat (15) frame_b(8'($urandom));
    repeat (10) frame_c(1'($urandom_range(0, 1)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
